coherent_averager: RTL and testbench

- Stream sink for the signal-generator output (data_valid / data / zero_cross).
- Accumulates 2^log2_ciclos full periods of ptos_x_ciclo samples, phase-aligned to zero_cross, into an internal accumulator RAM.
- Then drains the per-phase averages (one period) on a valid/ready output stream toward the processing chain / readout.

---
 rtl/coherent_averager_pkg.sv | 26 ++
 rtl/avg_acc_ram.sv | 22 ++
 rtl/coherent_averager.sv | 212 +++++++++++++++++++++
 tb/tb_coherent_averager.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coherent_averager_pkg.sv
// Shared constants, FSM state type and output scaling helper for coherent_averager.
package coherent_averager_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 11;
  localparam int MAX_LOG2 = 16;
  localparam int ACC_W    = DATA_W + MAX_LOG2;
  localparam int MAX_PTS  = 2 ** ADDR_W;
  localparam int CFG_W    = 16;
  localparam int LOG_W    = 5;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SYNC,
    ACCUM,
    DRAIN,
    DONE
  } state_t;

  // Divide an accumulated sum by 2^sh with floor rounding and keep the sample width.
  function automatic logic [DATA_W-1:0] shift_trunc(input logic signed [ACC_W-1:0] acc,
                                                    input logic [LOG_W-1:0] sh);
    return DATA_W'(acc >>> sh);
  endfunction

endpackage

// File: rtl/avg_acc_ram.sv
// Simple dual-port accumulator RAM: one write port, one synchronous read port.
module avg_acc_ram #(
  parameter int AW = 11,
  parameter int DW = 48
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  // Registered read and write; contents are never reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/coherent_averager.sv
// Coherent period averager: accumulates 2^L phase-aligned periods of M samples and
// drains the per-phase averages on a valid/ready stream.
// Optional build macro COHERENT_AVERAGER_SYNC_CHECK_EN adds the sync_err output and
// aborts a run when zero_cross disagrees with the phase index during accumulation.
module coherent_averager
  import coherent_averager_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CFG_W-1:0]  ptos_x_ciclo,
  input  logic [LOG_W-1:0]  log2_ciclos,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data,
  input  logic              zero_cross,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
`ifdef COHERENT_AVERAGER_SYNC_CHECK_EN
  output logic              cfg_err,
  output logic              sync_err
`else
  output logic              cfg_err
`endif
);

  localparam logic [MAX_LOG2:0] ONE_P = 1;

  state_t r_state, w_next;

  logic [CFG_W-1:0]  r_m;
  logic [LOG_W-1:0]  r_l;
  logic [ADDR_W-1:0] r_idx;
  logic [MAX_LOG2:0] r_period;
  logic              r_cfg_err;

  logic              r_wv;
  logic              r_wfirst;
  logic              r_wlast;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wsample;

  logic [ADDR_W:0]   r_ptr;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_ov;
  logic              r_olast;

  logic              w_cfg_ok;
  logic              w_idx_last;
  logic              w_per_last;
  logic              w_fin;
  logic              w_acc_in;
  logic              w_sync_bad;
  logic              w_take;
  logic              w_adv;
  logic              w_issue;
  logic              w_final;
  logic [ADDR_W-1:0] w_raddr;
  logic [ACC_W-1:0]  w_rdata;
  logic [ACC_W-1:0]  w_sext;
  logic [ACC_W-1:0]  w_wdata;

  assign w_cfg_ok   = (ptos_x_ciclo >= CFG_W'(2)) &&
                      ({16'd0, ptos_x_ciclo} <= 32'(MAX_PTS)) &&
                      ({27'd0, log2_ciclos} <= 32'(MAX_LOG2));
  assign w_idx_last = (CFG_W'(r_idx) == r_m - CFG_W'(1));
  assign w_per_last = (r_period == (ONE_P << r_l) - ONE_P);
  // The cycle after the final sample is captured its write is still pending; hold off new input.
  assign w_fin      = r_wv & r_wlast;
  assign w_acc_in   = (r_state == ACCUM) && data_valid && !w_fin;

`ifdef COHERENT_AVERAGER_SYNC_CHECK_EN
  assign w_sync_bad = w_acc_in && (zero_cross != (r_idx == '0));
`else
  assign w_sync_bad = 1'b0;
`endif

  assign w_take  = ((r_state == WAIT_SYNC) && data_valid && zero_cross) ||
                   (w_acc_in && !w_sync_bad);
  assign w_adv   = !r_ov || out_ready;
  assign w_final = (r_state == DRAIN) && r_ov && out_ready && r_olast;
  assign w_issue = (r_state == DRAIN) && w_adv && (CFG_W'(r_ptr) < r_m);
  // While stalled the read address is held so the registered RAM output stays stable.
  assign w_raddr = (r_state == DRAIN) ? (w_issue ? r_ptr[ADDR_W-1:0] : r_raddr) : r_idx;
  assign w_sext  = ACC_W'(signed'(r_wsample));
  assign w_wdata = r_wfirst ? w_sext : (w_rdata + w_sext);

  avg_acc_ram #(
    .AW(ADDR_W),
    .DW(ACC_W)
  ) u_ram (
    .clk    (clock),
    .i_we   (r_wv),
    .i_waddr(r_waddr),
    .i_wdata(w_wdata),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );

  assign out_valid = r_ov;
  assign out_last  = r_ov & r_olast;
  assign out_data  = r_ov ? shift_trunc(w_rdata, r_l) : '0;
  assign cfg_err   = r_cfg_err;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode plus busy/done.
  always_comb begin
    w_next = r_state;
    busy   = (r_state != IDLE);
    done   = 1'b0;
    case (r_state)
      IDLE:      if (start && w_cfg_ok) w_next = WAIT_SYNC;
      WAIT_SYNC: if (data_valid && zero_cross) w_next = ACCUM;
      ACCUM: begin
        if (w_sync_bad) w_next = IDLE;
        else if (w_fin) w_next = DRAIN;
      end
      DRAIN:     if (w_final) w_next = DONE;
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default:   w_next = IDLE;
    endcase
  end

  // Configuration latch, phase/period counters, write pipeline and drain control.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_m       <= '0;
      r_l       <= '0;
      r_idx     <= '0;
      r_period  <= '0;
      r_cfg_err <= 1'b0;
      r_wv      <= 1'b0;
      r_wfirst  <= 1'b0;
      r_wlast   <= 1'b0;
      r_waddr   <= '0;
      r_wsample <= '0;
      r_ptr     <= '0;
      r_raddr   <= '0;
      r_ov      <= 1'b0;
      r_olast   <= 1'b0;
    end else begin
      if ((r_state == IDLE) && start) begin
        r_m <= ptos_x_ciclo;
        r_l <= log2_ciclos;
        if (w_cfg_ok) begin
          r_cfg_err <= 1'b0;
          r_idx     <= '0;
          r_period  <= '0;
          r_ptr     <= '0;
        end else begin
          r_cfg_err <= 1'b1;
        end
      end

      if (w_take) begin
        r_wv      <= 1'b1;
        r_waddr   <= r_idx;
        r_wsample <= data;
        r_wfirst  <= (r_period == '0);
        r_wlast   <= w_idx_last && w_per_last;
        if (w_idx_last) begin
          r_idx    <= '0;
          r_period <= r_period + ONE_P;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end else begin
        r_wv    <= 1'b0;
        r_wlast <= 1'b0;
      end

      if (r_state == DRAIN) begin
        if (w_final) begin
          r_ov    <= 1'b0;
          r_olast <= 1'b0;
        end else if (w_issue) begin
          r_ov    <= 1'b1;
          r_olast <= (CFG_W'(r_ptr) == r_m - CFG_W'(1));
          r_raddr <= r_ptr[ADDR_W-1:0];
          r_ptr   <= r_ptr + 1'b1;
        end else if (w_adv) begin
          r_ov <= 1'b0;
        end
      end
    end
  end

`ifdef COHERENT_AVERAGER_SYNC_CHECK_EN
  logic r_sync_err;

  // Sticky phase-alignment error, cleared by the next valid start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                      r_sync_err <= 1'b0;
    else if ((r_state == IDLE) && start && w_cfg_ok)   r_sync_err <= 1'b0;
    else if (w_sync_bad)                               r_sync_err <= 1'b1;
  end

  assign sync_err = r_sync_err;
`endif

endmodule

// File: tb/tb_coherent_averager.sv
// Self-checking bench for coherent_averager with a behavioural per-phase average model.
module tb_coherent_averager;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] ptos_x_ciclo;
  logic [4:0]  log2_ciclos;
  logic        data_valid;
  logic [31:0] data;
  logic        zero_cross;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        cfg_err;
`ifdef COHERENT_AVERAGER_SYNC_CHECK_EN
  logic        sync_err;
`endif

  always #5 clock = ~clock;

  coherent_averager dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .ptos_x_ciclo(ptos_x_ciclo),
    .log2_ciclos (log2_ciclos),
    .data_valid  (data_valid),
    .data        (data),
    .zero_cross  (zero_cross),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
`ifdef COHERENT_AVERAGER_SYNC_CHECK_EN
    .cfg_err     (cfg_err),
    .sync_err    (sync_err)
`else
    .cfg_err     (cfg_err)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  logic signed [31:0] stim[$];
  logic signed [31:0] expq[$];
  logic signed [31:0] beats[$];
  bit                 lasts[$];
  int                 beat_cyc[$];
  int                 done_cnt;
  int                 done_cyc;
  int                 stall_bad;

  // Per-phase sum over all periods, divided by 2^l with floor rounding.
  task automatic model(input int m, input int l);
    expq.delete();
    for (int p = 0; p < m; p++) begin
      longint s = 0;
      longint n = longint'(1) << l;
      longint q;
      for (int k = p; k < stim.size(); k += m) s += longint'(stim[k]);
      q = s / n;
      if ((s % n) != 0 && s < 0) q = q - 1;
      expq.push_back(32'(q));
    end
  endtask

  task automatic do_start(input int m, input int l);
    @(posedge clock); #1;
    start        = 1'b1;
    ptos_x_ciclo = 16'(m);
    log2_ciclos  = 5'(l);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Pre-sync garbage, then stim with zero_cross on every index-0 sample and optional idle gaps.
  task automatic feed(input int m, input int pre, input int gap_max);
    for (int i = 0; i < pre; i++) begin
      data_valid = 1'b1; data = $urandom; zero_cross = 1'b0;
      @(posedge clock); #1;
    end
    for (int i = 0; i < stim.size(); i++) begin
      int g;
      g = $urandom_range(gap_max, 0);
      data_valid = 1'b0;
      repeat (g) begin @(posedge clock); #1; end
      data_valid = 1'b1; data = stim[i]; zero_cross = ((i % m) == 0);
      @(posedge clock); #1;
    end
    data_valid = 1'b0; zero_cross = 1'b0;
  endtask

  // Collect accepted beats under a ready pattern (0: always, 1: 1,0,0,1..., 2: random).
  task automatic collect(input int mode, input int max_cyc);
    logic signed [31:0] hold_d;
    bit                 hold_l;
    bit                 stalled;
    stalled = 1'b0; hold_d = '0; hold_l = 1'b0;
    beats.delete(); lasts.delete(); beat_cyc.delete();
    done_cnt = 0; done_cyc = -1; stall_bad = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(posedge clock); #1;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((c % 4) == 0) || ((c % 4) == 3);
        default: out_ready = 1'($urandom_range(1, 0));
      endcase
      @(negedge clock);
      if (stalled && (!out_valid || out_data !== hold_d || out_last !== hold_l)) stall_bad++;
      stalled = out_valid && !out_ready;
      hold_d  = out_data;
      hold_l  = out_last;
      if (out_valid && out_ready) begin
        beats.push_back(out_data);
        lasts.push_back(out_last);
        beat_cyc.push_back(c);
      end
      if (done) begin done_cnt++; done_cyc = c; end
      if (done_cnt > 0 && c >= done_cyc + 2) break;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if ({out_valid, out_data, out_last, busy, done, cfg_err} !== 37'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b d=%0d l=%b busy=%b done=%b cfg=%b, want all 0",
               out_valid, out_data, out_last, busy, done, cfg_err);
    end
`ifdef COHERENT_AVERAGER_SYNC_CHECK_EN
    n_cmp++;
    if (sync_err !== 1'b0) begin n_err++; $display("FAIL reset_sync_err: got %b want 0", sync_err); end
`endif
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_constant();
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(32'sd100);
    do_start(4, 2);
    feed(4, 3, 0);
    collect(0, 100);
    n_cmp++;
    if (beats.size() != 4) begin n_err++; $display("FAIL const_count: got %0d want 4", beats.size()); end
    for (int i = 0; i < beats.size(); i++) begin
      n_cmp++;
      if (beats[i] !== 32'sd100) begin n_err++; $display("FAIL const_data[%0d]: got %0d want 100", i, beats[i]); end
      n_cmp++;
      if (lasts[i] !== (i == 3)) begin n_err++; $display("FAIL const_last[%0d]: got %b want %b", i, lasts[i], i == 3); end
    end
    n_cmp++;
    if (done_cnt != 1) begin n_err++; $display("FAIL const_done_count: got %0d want 1", done_cnt); end
    if (beats.size() == 4) begin
      n_cmp++;
      if (beat_cyc[0] != 1 || beat_cyc[3] != 4 || done_cyc != 5) begin
        n_err++;
        $display("FAIL const_timing: got first=%0d last=%0d done=%0d want 1 4 5",
                 beat_cyc[0], beat_cyc[3], done_cyc);
      end
    end
  endtask

  task automatic test_ramp();
    stim.delete();
    for (int p = 0; p < 8; p++)
      for (int i = 0; i < 8; i++) stim.push_back(32'(i * 10 - 35));
    do_start(8, 3);
    feed(8, 2, 1);
    collect(0, 100);
    n_cmp++;
    if (beats.size() != 8) begin n_err++; $display("FAIL ramp_count: got %0d want 8", beats.size()); end
    for (int i = 0; i < beats.size(); i++) begin
      n_cmp++;
      if (beats[i] !== 32'(i * 10 - 35)) begin
        n_err++; $display("FAIL ramp_data[%0d]: got %0d want %0d", i, beats[i], i * 10 - 35);
      end
    end
    n_cmp++;
    if (done_cnt != 1) begin n_err++; $display("FAIL ramp_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_floor();
    stim.delete();
    stim.push_back(-32'sd3); stim.push_back(32'sd5);
    stim.push_back(-32'sd4); stim.push_back(32'sd6);
    do_start(2, 1);
    feed(2, 0, 0);
    collect(0, 50);
    n_cmp++;
    if (beats.size() != 2) begin n_err++; $display("FAIL floor_count: got %0d want 2", beats.size()); end
    else begin
      n_cmp++;
      if (beats[0] !== -32'sd4) begin n_err++; $display("FAIL floor_beat0: got %0d want -4", beats[0]); end
      n_cmp++;
      if (beats[1] !== 32'sd5) begin n_err++; $display("FAIL floor_beat1: got %0d want 5", beats[1]); end
      n_cmp++;
      if (lasts[0] !== 1'b0 || lasts[1] !== 1'b1) begin
        n_err++; $display("FAIL floor_last: got %b%b want 01", lasts[0], lasts[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back($urandom);
    model(4, 0);
    do_start(4, 0);
    feed(4, 1, 0);
    collect(1, 100);
    n_cmp++;
    if (beats.size() != 4) begin n_err++; $display("FAIL bp_count: got %0d want 4", beats.size()); end
    for (int i = 0; i < beats.size() && i < 4; i++) begin
      n_cmp++;
      if (beats[i] !== expq[i]) begin n_err++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, beats[i], expq[i]); end
    end
    n_cmp++;
    if (stall_bad != 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_bad); end
    n_cmp++;
    if (done_cnt != 1) begin n_err++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_cfg_err();
    do_start(1, 0);
    n_cmp++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL cfg_m1: got cfg=%b busy=%b want 1 0", cfg_err, busy);
    end
    do_start(4, 17);
    n_cmp++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL cfg_l17: got cfg=%b busy=%b want 1 0", cfg_err, busy);
    end
    do_start(2049, 0);
    n_cmp++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL cfg_m2049: got cfg=%b busy=%b want 1 0", cfg_err, busy);
    end
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back($urandom);
    do_start(4, 0);
    n_cmp++;
    if (cfg_err !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL cfg_clear: got cfg=%b busy=%b want 0 1", cfg_err, busy);
    end
    feed(4, 0, 0);
    collect(0, 50);
    n_cmp++;
    if (beats.size() != 4 || beats[0] !== stim[0] || beats[3] !== stim[3]) begin
      n_err++; $display("FAIL cfg_run: got %0d beats want 4 matching input", beats.size());
    end
  endtask

  task automatic test_reset_restart();
    stim.delete();
    for (int i = 0; i < 6; i++) stim.push_back(32'sd1000);
    do_start(4, 1);
    feed(4, 0, 0);
    #2 reset_n = 1'b0;
    #2;
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL midrun_reset: got busy=%b v=%b done=%b want 0 0 0", busy, out_valid, done);
    end
    @(negedge clock);
    reset_n = 1'b1;
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(32'sd7);
    do_start(4, 1);
    feed(4, 0, 0);
    collect(0, 50);
    n_cmp++;
    if (beats.size() != 4) begin n_err++; $display("FAIL restart_count: got %0d want 4", beats.size()); end
    for (int i = 0; i < beats.size(); i++) begin
      n_cmp++;
      if (beats[i] !== 32'sd7) begin n_err++; $display("FAIL restart_data[%0d]: got %0d want 7", i, beats[i]); end
    end
  endtask

`ifdef COHERENT_AVERAGER_SYNC_CHECK_EN
  task automatic test_sync_check();
    do_start(4, 1);
    for (int i = 0; i < 3; i++) begin
      data_valid = 1'b1; data = 32'(i + 1); zero_cross = (i != 1);
      @(posedge clock); #1;
    end
    data_valid = 1'b0; zero_cross = 1'b0;
    n_cmp++;
    if (sync_err !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL sync_abort: got sync_err=%b busy=%b want 1 0", sync_err, busy);
    end
    collect(0, 20);
    n_cmp++;
    if (done_cnt != 0 || beats.size() != 0) begin
      n_err++; $display("FAIL sync_no_drain: got done=%0d beats=%0d want 0 0", done_cnt, beats.size());
    end
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back(32'(i));
    do_start(4, 0);
    n_cmp++;
    if (sync_err !== 1'b0) begin n_err++; $display("FAIL sync_clear: got %b want 0", sync_err); end
    feed(4, 0, 0);
    collect(0, 50);
  endtask
`endif

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int m;
      int l;
      m = $urandom_range(12, 2);
      l = $urandom_range(3, 0);
      stim.delete();
      for (int i = 0; i < (m << l); i++) stim.push_back($urandom);
      model(m, l);
      do_start(m, l);
      feed(m, $urandom_range(3, 0), 2);
      collect(2, 400);
      n_cmp++;
      if (beats.size() != m) begin n_err++; $display("FAIL rand%0d_count: got %0d want %0d", r, beats.size(), m); end
      for (int i = 0; i < beats.size() && i < m; i++) begin
        n_cmp++;
        if (beats[i] !== expq[i] || lasts[i] !== (i == m - 1)) begin
          n_err++;
          $display("FAIL rand%0d_beat[%0d]: got %0d last=%b want %0d last=%b",
                   r, i, beats[i], lasts[i], expq[i], i == m - 1);
        end
      end
      n_cmp++;
      if (stall_bad != 0 || done_cnt != 1) begin
        n_err++; $display("FAIL rand%0d_flow: got stalls=%0d done=%0d want 0 1", r, stall_bad, done_cnt);
      end
    end
  endtask

  task automatic test_max_pts();
    int bad;
    bad = 0;
    stim.delete();
    for (int i = 0; i < 2048; i++) stim.push_back($urandom);
    model(2048, 0);
    do_start(2048, 0);
    feed(2048, 0, 0);
    collect(0, 2100);
    n_cmp++;
    if (beats.size() != 2048) begin n_err++; $display("FAIL maxpts_count: got %0d want 2048", beats.size()); end
    for (int i = 0; i < beats.size() && i < 2048; i++) begin
      n_cmp++;
      if (beats[i] !== expq[i]) begin
        n_err++;
        if (bad < 8) $display("FAIL maxpts_beat[%0d]: got %0d want %0d", i, beats[i], expq[i]);
        bad++;
      end
    end
    n_cmp++;
    if (beats.size() == 2048 && (lasts[2047] !== 1'b1 || beat_cyc[2047] - beat_cyc[0] != 2047)) begin
      n_err++; $display("FAIL maxpts_tail: got last=%b span=%0d want 1 2047", lasts[2047], beat_cyc[2047] - beat_cyc[0]);
    end
  endtask

  initial begin
    start = 1'b0; ptos_x_ciclo = '0; log2_ciclos = '0;
    data_valid = 1'b0; data = '0; zero_cross = 1'b0; out_ready = 1'b1;
    test_reset();
    test_constant();
    test_ramp();
    test_floor();
    test_backpressure();
    test_cfg_err();
    test_reset_restart();
`ifdef COHERENT_AVERAGER_SYNC_CHECK_EN
    test_sync_check();
`endif
    test_random();
    test_max_pts();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
